// File: rtl/sha256_uart_ctrl_if.sv
// UART byte link and SHA-256 core bus seen by the hasher command sequencer.
// The sequencer is the master; the UART/core side takes the slave view.
interface sha256_uart_ctrl_if;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         core_wr_en;
  logic [3:0]   core_wr_addr;
  logic [31:0]  core_wr_data;
  logic         core_init;
  logic         core_start;
  logic         core_done;
  logic [255:0] core_digest;

  modport master (
    input  rx_valid, rx_data, tx_ready, core_done, core_digest,
    output tx_data, tx_valid, core_wr_en, core_wr_addr, core_wr_data, core_init, core_start
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, core_done, core_digest,
    input  tx_data, tx_valid, core_wr_en, core_wr_addr, core_wr_data, core_init, core_start
  );
endinterface

// File: rtl/sha256_uart_ctrl.sv
// Command sequencer for the UART hasher: packs a 64-byte block into 16 big-endian
// words for the SHA-256 core, runs it, and streams the 32-byte digest back over UART.
module sha256_uart_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic               clk,
  input  logic               rst_n,
  sha256_uart_ctrl_if.master bus,
  output logic               busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, SEND, ERR} state_t;

  state_t          state, next_state;
  logic [23:0]     word_q;
  logic [5:0]      byte_cnt;
  logic [TW-1:0]   timer;
  logic            init_q;
  logic [255:0]    digest_q;
  logic [4:0]      tx_cnt;
  logic            load_done;
  logic            rx_take;
  logic            tx_fire;

  // The write of word 15 is in flight: the block is complete, bytes are no longer taken.
  assign load_done = bus.core_wr_en && (bus.core_wr_addr == 4'hF);
  assign rx_take   = bus.rx_valid && (state == LOAD) && !load_done;
  assign tx_fire   = bus.tx_valid && bus.tx_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state     = state;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.core_start = 1'b0;
    bus.core_init  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'h01 || bus.rx_data == 8'h02) next_state = LOAD;
          else                                                next_state = ERR;
        end
      end
      LOAD: begin
        if (load_done)                               next_state = START;
        else if (!bus.rx_valid && timer == TIMER_MAX) next_state = ERR;
      end
      START: begin
        bus.core_start = 1'b1;
        bus.core_init  = init_q;
        next_state     = WAIT;
      end
      WAIT: begin
        if (bus.core_done) next_state = SEND;
      end
      SEND: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = digest_q[255:248];
        if (tx_fire && tx_cnt == 5'd31) next_state = IDLE;
      end
      ERR: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = ERR_BYTE;
        if (bus.tx_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Byte packing, inter-byte timer and digest shift-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q           <= '0;
      byte_cnt         <= '0;
      timer            <= '0;
      init_q           <= 1'b0;
      digest_q         <= '0;
      tx_cnt           <= '0;
      bus.core_wr_en   <= 1'b0;
      bus.core_wr_addr <= '0;
      bus.core_wr_data <= '0;
    end else begin
      bus.core_wr_en <= 1'b0;
      if (state == IDLE && bus.rx_valid) init_q <= (bus.rx_data == 8'h01);

      if (state != LOAD) begin
        byte_cnt <= '0;
        timer    <= '0;
      end else if (rx_take) begin
        word_q   <= {word_q[15:0], bus.rx_data};
        byte_cnt <= byte_cnt + 6'd1;
        timer    <= '0;
        if (byte_cnt[1:0] == 2'd3) begin
          bus.core_wr_en   <= 1'b1;
          bus.core_wr_addr <= byte_cnt[5:2];
          bus.core_wr_data <= {word_q, bus.rx_data};
        end
      end else begin
        timer <= timer + TW'(1);
      end

      // Digest is captured once so the core may move on while bytes drain.
      if (state == WAIT && bus.core_done) begin
        digest_q <= bus.core_digest;
        tx_cnt   <= '0;
      end else if (state == SEND && tx_fire) begin
        digest_q <= {digest_q[247:0], 8'h00};
        tx_cnt   <= tx_cnt + 5'd1;
      end
    end
  end

endmodule
